// File: rtl/tick_rate_ctrl.sv
// Shared-prescaler tick scheduler: one base prescaler feeding four rate channels,
// each reconfigured through a valid/ready port that commits only on a period boundary.

module tick_rate_ch #(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 1000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_base_tick,
  input  logic             i_ld,
  input  logic [DIV_W-1:0] i_ld_div,
  input  logic             i_ld_en,
  output logic             o_tick,
  output logic             o_slow_clk,
  output logic             o_active,
  output logic             o_wrap
);
  logic [DIV_W-1:0] r_cnt, r_div;
  logic             r_en, r_tick, r_slow;
  logic             w_wrap;

  assign o_active   = r_en && (r_div != '0);
  assign w_wrap     = o_active && i_base_tick && (r_cnt == r_div - DIV_W'(1));
  assign o_wrap     = w_wrap;
  assign o_tick     = r_tick;
  assign o_slow_clk = r_slow;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_div  <= DIV_W'(DEFAULT_DIV);
      r_en   <= 1'b0;
      r_tick <= 1'b0;
      r_slow <= 1'b0;
    end else begin
      // The boundary tick/toggle fires even on a commit cycle: the old period completes.
      r_tick <= w_wrap;
      r_slow <= o_active & (r_slow ^ w_wrap);
      if (i_ld) begin
        r_div <= i_ld_div;
        r_en  <= i_ld_en;
        r_cnt <= '0;
      end else if (!o_active) begin
        r_cnt <= '0;
      end else if (i_base_tick) begin
        r_cnt <= w_wrap ? '0 : r_cnt + DIV_W'(1);
      end
    end
  end
endmodule

module tick_rate_ctrl #(
  parameter int PRESCALE    = 1000,
  parameter int DEFAULT_DIV = 1000,
  parameter int DIV_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cfg_valid,
  output logic             o_cfg_ready,
  input  logic [1:0]       i_cfg_ch,
  input  logic [DIV_W-1:0] i_cfg_div,
  input  logic             i_cfg_en,
  output logic [3:0]       o_tick,
  output logic [3:0]       o_slow_clk,
  output logic [3:0]       o_ch_active,
  output logic             o_busy
);
  localparam int NUM_CH = 4;
  localparam int PW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic {S_IDLE, S_PEND} state_t;

  state_t              r_state, w_next;
  logic [PW-1:0]       r_pre_cnt;
  logic                w_base_tick;
  logic [1:0]          r_pch;
  logic [DIV_W-1:0]    r_pdiv;
  logic                r_pen;
  logic                w_commit;
  logic [NUM_CH-1:0]   w_active, w_wrap, w_ld;

  assign w_base_tick = (r_pre_cnt == PW'(PRESCALE - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_pre_cnt <= '0;
    else          r_pre_cnt <= w_base_tick ? '0 : r_pre_cnt + PW'(1);
  end

  assign o_cfg_ready = (r_state == S_IDLE);
  assign o_busy      = (r_state == S_PEND);

  // An inactive target has no period to protect, so it commits at once.
  always_comb begin
    w_next   = r_state;
    w_commit = 1'b0;
    case (r_state)
      S_IDLE: if (i_cfg_valid) w_next = S_PEND;
      S_PEND: if (!w_active[r_pch] || w_wrap[r_pch]) begin
        w_commit = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_pch   <= '0;
      r_pdiv  <= '0;
      r_pen   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (i_cfg_valid && o_cfg_ready) begin
        r_pch  <= i_cfg_ch;
        r_pdiv <= i_cfg_div;
        r_pen  <= i_cfg_en;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_ld[g] = w_commit && (r_pch == 2'(g));
    tick_rate_ch #(.DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV)) u_ch (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_base_tick(w_base_tick),
      .i_ld       (w_ld[g]),
      .i_ld_div   (r_pdiv),
      .i_ld_en    (r_pen),
      .o_tick     (o_tick[g]),
      .o_slow_clk (o_slow_clk[g]),
      .o_active   (w_active[g]),
      .o_wrap     (w_wrap[g])
    );
  end

  assign o_ch_active = w_active;
endmodule

// File: doc/tick_rate_ctrl.md
Name: tick_rate_ctrl

Overview:
- Shared-prescaler tick scheduler. Replaces per-consumer free-running slow-clock dividers with one base prescaler and four programmable rate channels.
- Each channel emits a one-cycle clock-enable pulse and a square-wave level output.
- Channels are reconfigured at runtime through a valid/ready port.
- Updates commit only at a channel period boundary, so no runt periods reach downstream display/debounce logic.

Parameters:
PRESCALE, 1000, clk cycles per base tick (>=1); 100 MHz -> 100 kHz base
DEFAULT_DIV, 1000, reset divisor for every channel, in base ticks
DIV_W, 16, divisor and channel counter width

Ports:
clk  in  1  system clock, 100 MHz
rst_n  in  1  asynchronous active-low reset
cfg_valid  in  1  config request valid
cfg_ready  out  1  config port can accept a request
cfg_ch  in  2  target channel index
cfg_div  in  DIV_W  new divisor (base ticks per tick pulse)
cfg_en  in  1  new channel enable
tick  out  4  per-channel one-cycle enable pulse
slow_clk  out  4  per-channel level output, toggles on each tick
ch_active  out  4  per-channel enabled AND divisor != 0
busy  out  1  config update pending

Behaviour:
- Reset, asynchronous on rst_n low:
  - pre_cnt=0, all channel counters=0, div[i]=DEFAULT_DIV, en[i]=0.
  - tick=0, slow_clk=0, state=IDLE, cfg_ready=1, busy=0.
- Prescaler:
  - pre_cnt counts 0..PRESCALE-1 and wraps.
  - base_tick is an internal pulse when pre_cnt==PRESCALE-1.
  - With PRESCALE=1, base_tick is high every cycle.
  - The prescaler always runs and never restarts on a config write.
- Channel i is active when en[i]=1 and div[i]!=0. ch_active[i] is combinational from the committed registers.
- Active channel:
  - On base_tick, cnt increments.
  - At base_tick with cnt==div-1: cnt<=0, tick[i]<=1 for exactly one cycle, slow_clk[i]<=~slow_clk[i].
  - tick and slow_clk are registered; they appear one clk after the wrapping base_tick cycle.
  - Tick period = PRESCALE*div clk cycles; slow_clk period = 2*PRESCALE*div.
- Inactive channel: cnt held 0, tick 0, slow_clk forced 0 on the next clk.
- Config FSM, states IDLE and PEND:
  - cfg_ready = (state==IDLE); busy = (state==PEND).
  - IDLE: a transfer occurs when cfg_valid and cfg_ready. It captures p_ch, p_div and p_en, then moves to PEND.
  - PEND commit condition, target channel inactive: commit on the first PEND cycle.
  - PEND commit condition, target channel active: commit in the cycle where base_tick and cnt==div-1 for p_ch. That boundary's tick and toggle still fire; the old period completes.
  - On commit: div[p_ch]<=p_div, en[p_ch]<=p_en, cnt[p_ch]<=0, state<=IDLE.
  - cfg_ready returns high the cycle after commit.
  - Other channels are never disturbed.
  - Only one request is outstanding; further cfg_valid is ignored while cfg_ready=0.
- Commit to an inactive result (p_en=0 or p_div=0): slow_clk[p_ch] goes to 0 the next cycle; no further ticks.
- Commit activating a channel: cnt starts at 0 and slow_clk starts at 0. The first tick comes after p_div full base ticks, counted from the base tick after commit.
- Divisor 1: a tick on every base tick. With PRESCALE=1 tick stays high continuously, and slow_clk toggles every cycle.
- Counter arithmetic is DIV_W-bit unsigned. With cnt < div guaranteed, there is no overflow. The maximum period is (2^DIV_W-1) base ticks.
- Reset mid-operation, including in PEND: the pending request is discarded and all state returns to reset values.

Test Plan:
- Reset/defaults: PRESCALE=4, DEFAULT_DIV=3, hold rst_n low 5 cycles then release -> all outputs 0, cfg_ready=1, ch_active=0000 indefinitely.
- Enable from idle:
  - Stimulus: PRESCALE=4; write ch0 div=3 en=1.
  - Commit/ready: commit one cycle after handshake; cfg_ready back high 2 cycles after handshake.
  - Output: tick[0] pulses every 12 clk; slow_clk[0] period 24 clk.
  - Other channels: tick[3:1]=0.
- Boundary-synchronised reload:
  - Stimulus: ch1 running div=5; write div=2 mid-period.
  - During PEND: busy=1, cfg_ready=0; the old 20-clk period completes with its tick.
  - After commit: subsequent tick spacing is 8 clk; no runt period.
- Backpressure: assert cfg_valid continuously with changing payloads while busy -> only the payload present at the handshake cycle is committed, and the next transfer occurs only once cfg_ready=1.
- Disable and divisor zero:
  - Write ch2 en=1 div=0 -> ch_active[2]=0, no ticks.
  - Write ch2 en=0 to a running channel -> after boundary commit, slow_clk[2] is 0 and ticks stop.
- Async reset in PEND: assert rst_n low between clk edges during PEND -> outputs clear immediately; after release the old request is not applied, div=DEFAULT_DIV and en=0.
